// File: rtl/counter_request_arbiter_pkg.sv
// Shared counter-request definitions: direction codes, channel limit,
// offer FSM states and an elaboration-time log2 helper.
package agc_cntr_pkg;

  localparam logic DIR_PINC = 1'b0;
  localparam logic DIR_MINC = 1'b1;
  localparam int   NCH_MAX  = 32;

  typedef enum logic {
    OFF_IDLE = 1'b0,
    OFF_HOLD = 1'b1
  } offer_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < NCH_MAX; i++)
      if ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/counter_request_arbiter_if.sv
// Request handshake between the arbiter (master) and the
// counter-cell service sequencer (slave).
interface counter_request_arbiter_if #(
  parameter int NCH = 8
);
  import agc_cntr_pkg::*;

  localparam int CHW = clog2(NCH);

  logic           req_valid;
  logic [CHW-1:0] req_ch;
  logic           req_dir;
  logic           req_ack;

  modport master (
    output req_valid,
    output req_ch,
    output req_dir,
    input  req_ack
  );

  modport slave (
    input  req_valid,
    input  req_ch,
    input  req_dir,
    output req_ack
  );

endinterface

// File: rtl/counter_request_arbiter_sync.sv
// pulse_sync_edge: multi-flop synchroniser, history flop and
// single-cycle rising-edge strobe for one asynchronous pulse line.
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK,
  input  logic rst_,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/counter_request_arbiter.sv
// Counter request arbiter: pulse sync, pending/lost tracking, offer.
// Define CRA_ROUND_ROBIN_EN for rotating channel priority.
module counter_request_arbiter
  import agc_cntr_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLOCK,
  input  logic                      rst_,
  input  logic [NCH-1:0]            pls_p,
  input  logic [NCH-1:0]            pls_m,
  input  logic [NCH-1:0]            chan_en,
  counter_request_arbiter_if.master rq,
  output logic [NCH-1:0]            lost,
  input  logic [NCH-1:0]            lost_clr,
  output logic                      busy
);

  localparam int CHW = clog2(NCH);
  localparam logic [NCH-1:0] ONE = NCH'(1);

  logic [NCH-1:0] rise_p, rise_m;
  logic [SYNC_STAGES:0] arm_q;
  logic armed;

  logic [NCH-1:0] pend_p_q, pend_m_q;
  logic [NCH-1:0] pend_p_d, pend_m_d;
  logic [NCH-1:0] lost_q, lost_d;
  logic [NCH-1:0] stb_p, stb_m, pair;
  logic [NCH-1:0] set_p, set_m;
  logic [NCH-1:0] ch_oh, off_p, off_m;
  logic [NCH-1:0] ack_p, ack_m;
  logic [NCH-1:0] cancel, drop_p, drop_m;
  logic [NCH-1:0] elig_p, elig_m;
  logic [NCH-1:0] evt_lost;

  offer_state_e   st_q, st_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           dir_q, dir_d;
  logic           ack_fire;
  logic           busy_q, busy_d;

  logic           sel_vld;
  logic [CHW-1:0] sel_ch;
  logic           sel_dir;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sp (
      .CLOCK(CLOCK),
      .rst_ (rst_),
      .din  (pls_p[i]),
      .rise (rise_p[i])
    );
    pulse_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sm (
      .CLOCK(CLOCK),
      .rst_ (rst_),
      .din  (pls_m[i]),
      .rise (rise_m[i])
    );
  end

  // Strobes stay masked until the history flop holds a post-reset sample,
  // so a line already high at reset release is not counted.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) arm_q <= '0;
    else       arm_q <= {arm_q[SYNC_STAGES-1:0], 1'b1};
  end

  assign armed = arm_q[SYNC_STAGES];

  assign stb_p = rise_p & chan_en & {NCH{armed}};
  assign stb_m = rise_m & chan_en & {NCH{armed}};

  assign ack_fire = (st_q == OFF_HOLD) & rq.req_ack;

  assign ch_oh = ONE << ch_q;
  assign off_p = ch_oh & {NCH{(st_q == OFF_HOLD) && (dir_q == DIR_PINC)}};
  assign off_m = ch_oh & {NCH{(st_q == OFF_HOLD) && (dir_q == DIR_MINC)}};
  assign ack_p = off_p & {NCH{rq.req_ack}};
  assign ack_m = off_m & {NCH{rq.req_ack}};

  assign pair  = stb_p & stb_m & ~pend_p_q & ~pend_m_q;
  assign set_p = stb_p & ~pair;
  assign set_m = stb_m & ~pair;

  assign cancel = pend_p_q & pend_m_q & ~off_p & ~off_m;
  assign drop_p = cancel | (~chan_en & ~off_p);
  assign drop_m = cancel | (~chan_en & ~off_m);

  assign pend_p_d = ((pend_p_q & ~ack_p) | set_p) & ~drop_p;
  assign pend_m_d = ((pend_m_q & ~ack_m) | set_m) & ~drop_m;

  assign evt_lost = (set_p & pend_p_q & ~ack_p)
                  | (set_m & pend_m_q & ~ack_m);
  assign lost_d   = (lost_q & ~lost_clr) | evt_lost;

  assign elig_p = pend_p_q & ~drop_p;
  assign elig_m = pend_m_q & ~drop_m;

`ifdef CRA_ROUND_ROBIN_EN
  logic [CHW-1:0] ptr_q;
  int             rr_idx;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_)         ptr_q <= CHW'(NCH - 1);
    else if (ack_fire) ptr_q <= ch_q;
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_ch  = '0;
    sel_dir = DIR_PINC;
    rr_idx  = 0;
    for (int k = NCH; k >= 1; k--) begin
      rr_idx = (int'(ptr_q) + k) % NCH;
      if (elig_p[rr_idx] | elig_m[rr_idx]) begin
        sel_vld = 1'b1;
        sel_ch  = CHW'(rr_idx);
        sel_dir = elig_p[rr_idx] ? DIR_PINC : DIR_MINC;
      end
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0;
    sel_ch  = '0;
    sel_dir = DIR_PINC;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig_p[i] | elig_m[i]) begin
        sel_vld = 1'b1;
        sel_ch  = CHW'(i);
        sel_dir = elig_p[i] ? DIR_PINC : DIR_MINC;
      end
    end
  end
`endif

  always_comb begin
    st_d  = st_q;
    ch_d  = ch_q;
    dir_d = dir_q;
    unique case (1'b1)
      (st_q == OFF_IDLE) && sel_vld: begin
        st_d  = OFF_HOLD;
        ch_d  = sel_ch;
        dir_d = sel_dir;
      end
      ack_fire: st_d = OFF_IDLE;
      default: ;
    endcase
  end

  assign busy_d = (|pend_p_d) | (|pend_m_d) | (st_d == OFF_HOLD);

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      st_q     <= OFF_IDLE;
      ch_q     <= '0;
      dir_q    <= DIR_PINC;
      pend_p_q <= '0;
      pend_m_q <= '0;
      lost_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      ch_q     <= ch_d;
      dir_q    <= dir_d;
      pend_p_q <= pend_p_d;
      pend_m_q <= pend_m_d;
      lost_q   <= lost_d;
      busy_q   <= busy_d;
    end
  end

  assign rq.req_valid = (st_q == OFF_HOLD);
  assign rq.req_ch    = ch_q;
  assign rq.req_dir   = dir_q;
  assign lost         = lost_q;
  assign busy         = busy_q;

endmodule
